// File: rtl/reduction_ctrl.sv
// Pass sequencer for a bank of parallel reduction lanes: feeds N_COLS columns, collects per-lane sums.
// Optional cycle counter on perf_cycles is built only when REDUCTION_CTRL_PERF_EN is defined.
module reduction_ctrl #(
    parameter int N_MATS        = 10,
    parameter int DATA_WIDTH    = 16,
    parameter int N_COLS        = 4,
    parameter int DRAIN_TIMEOUT = 16
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         start,
    output logic                         busy,
    input  logic                         in_valid,
    output logic                         in_ready,
    output logic                         red_valid_in,
    input  logic [N_MATS-1:0]            red_valid_out,
    input  logic [N_MATS*DATA_WIDTH-1:0] red_sum,
    output logic                         res_valid,
    input  logic                         res_ready,
    output logic [N_MATS*DATA_WIDTH-1:0] res_data,
    output logic                         err,
    output logic [31:0]                  perf_cycles
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_FEED,
        S_DRAIN,
        S_OUTPUT
    } state_t;

    localparam logic [7:0] LAST_COL   = 8'(N_COLS - 1);
    localparam logic [7:0] LAST_DRAIN = 8'(DRAIN_TIMEOUT - 1);

    state_t            state;
    logic [7:0]        col_cnt;
    logic [7:0]        drain_cnt;
    logic [N_MATS-1:0] mask;

    logic              accept;
    logic              capture_en;
    logic              last_col;
    logic              enter_feed;
    logic              drain_done;
    logic              drain_expired;
    logic [N_MATS-1:0] cap_hit;
    logic [N_MATS-1:0] mask_next;

    // The column handshake is combinational so the array sees valid_in in the accept cycle.
    assign in_ready     = (state == S_FEED);
    assign accept       = in_valid & in_ready;
    assign red_valid_in = accept;

    // Only the first pulse per lane is kept; the mask blocks later ones.
    assign capture_en    = (state == S_FEED) || (state == S_DRAIN);
    assign cap_hit       = capture_en ? (red_valid_out & ~mask) : '0;
    assign mask_next     = mask | cap_hit;

    assign last_col      = accept && (col_cnt == LAST_COL);
    assign enter_feed    = start && ((state == S_IDLE) || ((state == S_OUTPUT) && res_ready));
    assign drain_done    = &mask_next;
    assign drain_expired = (drain_cnt == LAST_DRAIN);

    // NOTE: every register here is assigned with <= so all of them see the pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            busy      <= 1'b0;
            res_valid <= 1'b0;
            err       <= 1'b0;
            col_cnt   <= '0;
            drain_cnt <= '0;
            mask      <= '0;
            // NOTE: res_data is a flop array driving an output, so it is reset rather than left unknown.
            res_data  <= '0;
        end else begin
            for (int i = 0; i < N_MATS; i++) begin
                if (cap_hit[i]) begin
                    res_data[i*DATA_WIDTH +: DATA_WIDTH] <= red_sum[i*DATA_WIDTH +: DATA_WIDTH];
                end
            end
            mask <= mask_next;

            case (state)
                S_IDLE: begin
                    if (enter_feed) begin
                        state     <= S_FEED;
                        busy      <= 1'b1;
                        col_cnt   <= '0;
                        drain_cnt <= '0;
                        mask      <= '0;
                        res_data  <= '0;
                        err       <= 1'b0;
                    end
                end

                S_FEED: begin
                    if (accept) begin
                        col_cnt <= col_cnt + 8'd1;
                        if (last_col) begin
                            state <= S_DRAIN;
                        end
                    end
                end

                S_DRAIN: begin
                    if (drain_done) begin
                        state     <= S_OUTPUT;
                        res_valid <= 1'b1;
                        err       <= 1'b0;
                    end else if (drain_expired) begin
                        state     <= S_OUTPUT;
                        res_valid <= 1'b1;
                        err       <= 1'b1;
                    end else begin
                        drain_cnt <= drain_cnt + 8'd1;
                    end
                end

                S_OUTPUT: begin
                    if (res_ready) begin
                        res_valid <= 1'b0;
                        if (enter_feed) begin
                            // Back-to-back pass: restart without visiting IDLE.
                            state     <= S_FEED;
                            col_cnt   <= '0;
                            drain_cnt <= '0;
                            mask      <= '0;
                            res_data  <= '0;
                            err       <= 1'b0;
                        end else begin
                            state <= S_IDLE;
                            busy  <= 1'b0;
                        end
                    end
                end

                default: begin
                    state     <= S_IDLE;
                    busy      <= 1'b0;
                    res_valid <= 1'b0;
                end
            endcase
        end
    end

`ifdef REDUCTION_CTRL_PERF_EN
    logic [31:0] perf_cnt;

    // The cycle that launches a pass counts as its first cycle; the handshake cycle is the last.
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_cnt <= '0;
        end else if (enter_feed) begin
            perf_cnt <= 32'd1;
        end else if ((state != S_IDLE) && (perf_cnt != 32'hFFFF_FFFF)) begin
            perf_cnt <= perf_cnt + 32'd1;
        end
    end

    assign perf_cycles = perf_cnt;
`else
    assign perf_cycles = '0;
`endif

endmodule

// File: tb/tb_reduction_ctrl.sv
// Directed bench for reduction_ctrl with N_MATS=10, DATA_WIDTH=16, N_COLS=4, DRAIN_TIMEOUT=16.
// Expects perf_cycles per pass when REDUCTION_CTRL_PERF_EN is defined, otherwise 0.
module tb_reduction_ctrl;

    logic         clk;
    logic         rst;
    logic         start;
    logic         busy;
    logic         in_valid;
    logic         in_ready;
    logic         red_valid_in;
    logic [9:0]   red_valid_out;
    logic [159:0] red_sum;
    logic         res_valid;
    logic         res_ready;
    logic [159:0] res_data;
    logic         err;
    logic [31:0]  perf_cycles;

    int vectors     = 0;
    int miscompares = 0;

    logic [159:0] exp_sums;
    logic [159:0] exp_partial;
    logic [31:0]  exp_perf_straight;
    logic [31:0]  exp_perf_toggle;

    int   pulses;
    int   lat;
    logic drain_ready;

    reduction_ctrl #(
        .N_MATS       (10),
        .DATA_WIDTH   (16),
        .N_COLS       (4),
        .DRAIN_TIMEOUT(16)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .busy         (busy),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .red_valid_in (red_valid_in),
        .red_valid_out(red_valid_out),
        .red_sum      (red_sum),
        .res_valid    (res_valid),
        .res_ready    (res_ready),
        .res_data     (res_data),
        .err          (err),
        .perf_cycles  (perf_cycles)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [159:0] observed, input logic [159:0] expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Starts a pass in the current cycle; lanes pulse once, one cycle after the 4th accept.
    task automatic run_pass(input bit toggle, input logic [9:0] lanes,
                            output int n_pulses, output int latency, output logic rdy_after);
        int fed_at;
        n_pulses  = 0;
        latency   = -1;
        fed_at    = -1;
        rdy_after = 1'b1;
        start     = 1'b1;
        in_valid  = 1'b1;
        for (int c = 0; c < 60; c++) begin
            red_valid_out = (fed_at >= 0 && c == fed_at + 1) ? lanes : 10'd0;
            #1;
            if (fed_at >= 0 && c == fed_at + 1) rdy_after = in_ready;
            if (red_valid_in) begin
                n_pulses++;
                if (n_pulses == 4) fed_at = c;
            end
            @(posedge clk);
            #1;
            start = 1'b0;
            if (toggle) in_valid = ~in_valid;
            if (res_valid) begin
                latency = c + 1;
                break;
            end
        end
        red_valid_out = '0;
        in_valid      = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        for (int i = 0; i < 10; i++) exp_sums[i*16 +: 16] = 16'h0100 + 16'(i);
        exp_partial = exp_sums;
        exp_partial[9*16 +: 16] = 16'h0000;
`ifdef REDUCTION_CTRL_PERF_EN
        exp_perf_straight = 32'd7;
        exp_perf_toggle   = 32'd11;
`else
        exp_perf_straight = 32'd0;
        exp_perf_toggle   = 32'd0;
`endif

        rst = 1'b1; start = 1'b0; in_valid = 1'b0; res_ready = 1'b0;
        red_valid_out = '0; red_sum = exp_sums;
        tick();
        tick();
        check("rst_busy", busy, 0);
        check("rst_in_ready", in_ready, 0);
        check("rst_res_valid", res_valid, 0);
        check("rst_res_data", res_data, 0);
        check("rst_err", err, 0);
        check("rst_perf", perf_cycles, 0);
        rst = 1'b0;
        tick();

        // Straight pass: in_valid held high, all lanes complete in the first DRAIN cycle.
        run_pass(1'b0, 10'h3FF, pulses, lat, drain_ready);
        check("p1_pulses", pulses, 4);
        check("p1_latency", lat, 6);
        check("p1_drain_in_ready", drain_ready, 0);
        check("p1_res_data", res_data, exp_sums);
        check("p1_err", err, 0);
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
        check("p1_res_valid_after_hs", res_valid, 0);
        check("p1_busy_after_hs", busy, 0);
        check("p1_perf", perf_cycles, exp_perf_straight);
        tick();

        // Toggling in_valid: accepts on every other cycle.
        run_pass(1'b1, 10'h3FF, pulses, lat, drain_ready);
        check("p2_pulses", pulses, 4);
        check("p2_latency", lat, 10);
        check("p2_drain_in_ready", drain_ready, 0);
        check("p2_res_data", res_data, exp_sums);
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
        check("p2_perf", perf_cycles, exp_perf_toggle);
        tick();

        // Lane 9 never reports: timeout after 16 DRAIN cycles.
        run_pass(1'b0, 10'h1FF, pulses, lat, drain_ready);
        check("p3_latency", lat, 21);
        check("p3_err", err, 1);
        check("p3_res_data", res_data, exp_partial);
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
        check("p3_busy_after_hs", busy, 0);
        tick();

        // Stall in OUTPUT while lane 3 re-pulses with a different value.
        run_pass(1'b0, 10'h3FF, pulses, lat, drain_ready);
        check("p4_latency", lat, 6);
        red_sum[3*16 +: 16] = 16'hFFFF;
        red_valid_out = 10'h008;
        for (int k = 0; k < 5; k++) begin
            tick();
            check("p4_hold_res_valid", res_valid, 1);
        end
        check("p4_hold_res_data", res_data, exp_sums);
        check("p4_hold_err", err, 0);
        red_valid_out = '0;
        red_sum = exp_sums;
        start = 1'b1;
        res_ready = 1'b1;
        tick();
        start = 1'b0;
        res_ready = 1'b0;
        check("p4_b2b_busy", busy, 1);
        check("p4_b2b_in_ready", in_ready, 1);
        check("p4_b2b_res_valid", res_valid, 0);

        // Two accepts into the back-to-back pass, then reset.
        in_valid = 1'b1;
        tick();
        tick();
        rst = 1'b1;
        tick();
        check("p5_rst_busy", busy, 0);
        check("p5_rst_in_ready", in_ready, 0);
        check("p5_rst_red_valid_in", red_valid_in, 0);
        check("p5_rst_res_valid", res_valid, 0);
        check("p5_rst_res_data", res_data, 0);
        check("p5_rst_err", err, 0);
        check("p5_rst_perf", perf_cycles, 0);
        rst = 1'b0;
        in_valid = 1'b0;
        for (int k = 0; k < 8; k++) tick();
        check("p5_no_result", res_valid, 0);

        run_pass(1'b0, 10'h3FF, pulses, lat, drain_ready);
        check("p6_pulses", pulses, 4);
        check("p6_latency", lat, 6);
        check("p6_res_data", res_data, exp_sums);
        check("p6_err", err, 0);
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
        check("p6_perf", perf_cycles, exp_perf_straight);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/reduction_ctrl.md
REDUCTION_CTRL -- requirements
Module: reduction_ctrl

Interface
REQ-001 SHALL have parameter N_MATS, default 10, number of parallel reduction lanes sequenced.
REQ-002 SHALL have parameter DATA_WIDTH, default 16, per-lane sum width.
REQ-003 SHALL have parameter N_COLS, default 4, 2-row columns fed per pass; range 1..255.
REQ-004 SHALL have parameter DRAIN_TIMEOUT, default 16, maximum DRAIN cycles before abort; range 1..255.
REQ-005 SHALL have port clk, input, 1, the single clock; all logic on its rising edge.
REQ-006 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-007 SHALL have port start, input, 1, request to begin a pass.
REQ-008 SHALL have port busy, output, 1, high in any state other than IDLE.
REQ-009 SHALL have port in_valid, input, 1, upstream column available.
REQ-010 SHALL have port in_ready, output, 1, controller accepts a column.
REQ-011 SHALL have port red_valid_in, output, 1, drives the array valid_in.
REQ-012 SHALL have port red_valid_out, input, N_MATS, per-lane valid from the array.
REQ-013 SHALL have port red_sum, input, N_MATS*DATA_WIDTH, lane i at bits [i*DATA_WIDTH +: DATA_WIDTH].
REQ-014 SHALL have port res_valid, output, 1, result vector valid.
REQ-015 SHALL have port res_ready, input, 1, downstream accepts the result.
REQ-016 SHALL have port res_data, output, N_MATS*DATA_WIDTH, captured sums, same packing as red_sum.
REQ-017 SHALL have port err, output, 1, high with res_valid when the pass timed out.
REQ-018 SHALL have port perf_cycles, output, 32, pass cycle count (see Configuration).

Function
REQ-019 SHALL implement states IDLE, FEED, DRAIN, OUTPUT.
REQ-020 IDLE: start=1 -> FEED next cycle; clears column count, capture mask, res_data, err, timeout counter.
REQ-021 FEED: in_ready=1 combinationally; accept = in_valid & in_ready; red_valid_in = accept, same cycle, no register.
REQ-022 FEED: column count increments per accept; accept bringing count to N_COLS -> DRAIN next cycle.
REQ-023 in_ready and red_valid_in SHALL be 0 outside FEED.
REQ-024 In FEED and DRAIN, each cycle red_valid_out[i]=1 with mask[i]=0 captures lane i of red_sum into res_data and sets mask[i]; first capture wins, later pulses on that lane are ignored.
REQ-025 red_valid_out in IDLE or OUTPUT SHALL be ignored.
REQ-026 DRAIN: mask all-ones (including captures landing this cycle) -> OUTPUT next cycle, err=0.
REQ-027 DRAIN: timeout counter increments per DRAIN cycle; reaching DRAIN_TIMEOUT with mask incomplete -> OUTPUT, err=1, uncaptured lanes read 0.
REQ-028 OUTPUT: res_valid=1; res_data and err SHALL hold stable until res_valid & res_ready.
REQ-029 On result handshake: -> FEED if start=1 that cycle (back-to-back pass, counters cleared), else IDLE.
REQ-030 start outside IDLE and the OUTPUT handshake cycle SHALL be ignored.
REQ-031 Minimum latency start -> res_valid SHALL be N_COLS+2 cycles with in_valid held high and all lanes valid on the last accept cycle.

Reset
REQ-032 rst=1 SHALL, at the next clk edge, force IDLE and zero busy, in_ready, red_valid_in, res_valid, res_data, err, mask, all counters, perf_cycles, regardless of state, including mid-FEED and mid-OUTPUT.
REQ-033 A pass interrupted by rst SHALL produce no result; the array is reset on the same rst.

Configuration
REQ-034 Macro REDUCTION_CTRL_PERF_EN defined: perf_cycles counts cycles from the FEED-entry cycle through the result handshake cycle inclusive, holds its value in IDLE, and clears on the next FEED entry; saturates at 2^32-1.
REQ-035 Macro REDUCTION_CTRL_PERF_EN undefined: perf_cycles SHALL be constant 0 and no counter logic is synthesised; all other behaviour is identical.

Verification (N_MATS=10, DATA_WIDTH=16, N_COLS=4, DRAIN_TIMEOUT=16)
REQ-036 start pulse, in_valid held 1, all lanes valid 1 cycle after 4th accept with lane i sum=0x0100+i -> exactly 4 red_valid_in pulses, res_valid 6 cycles after start, res_data lane i=0x0100+i, err=0.
REQ-037 in_valid toggling 1,0,1,0,... -> red_valid_in only on accept cycles, still exactly 4 pulses, DRAIN entered after 4th accept.
REQ-038 lanes 0-8 valid, lane 9 never -> err=1 after 16 DRAIN cycles, lane 9 reads 0x0000, lanes 0-8 correct.
REQ-039 res_ready held 0 for 5 cycles in OUTPUT with lane 3 re-pulsing 0xFFFF -> res_data stable, lane 3 unchanged; start=1 with handshake -> FEED next cycle.
REQ-040 rst asserted after 2nd accept -> next cycle IDLE, all outputs 0, no res_valid; new start runs a clean full pass.
REQ-041 With REDUCTION_CTRL_PERF_EN, REQ-036 pass with res_ready=1 -> perf_cycles=7; without macro -> perf_cycles=0.
